// File: rtl/alu_inst_issuer_pkg.sv
// Shared types for the ALU instruction issuer and the ALU it drives.
// Contents:
//   data_y          - signed ALU operand/result word
//   opcode_t        - ALU operations ADD, SUB, MUL, DIV, VAR
//   INST_t          - one instruction {opc, op_a, op_b}
//   issuer_state_t  - issuer FSM states
//   is_zero_div()   - true when an instruction divides by zero
package lab_MS_SV4_pack;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_y;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    VAR = 3'd4
  } opcode_t;

  typedef struct packed {
    opcode_t opc;
    data_y   op_a;
    data_y   op_b;
  } INST_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } issuer_state_t;

  // DIV and VAR both divide by op_b, so a zero op_b makes the ALU result meaningless.
  function automatic logic is_zero_div(input INST_t inst);
    return ((inst.opc == DIV) || (inst.opc == VAR)) && (inst.op_b == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_inst_issuer_inst_mem.sv
// Program memory for the issuer: DEPTH instructions, synchronous write,
// asynchronous read. Contents are deliberately not reset so a program
// survives an aborted run.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - instruction to store
//   raddr  - read address
//   rdata  - instruction at raddr (combinational)
module inst_mem
  import lab_MS_SV4_pack::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  INST_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output INST_t                    rdata
);

  INST_t mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_inst_issuer.sv
// Steps through a stored program, drives one instruction at a time to an
// external ALU, waits ALU_LAT cycles, captures the result and flags
// divide-by-zero. All outputs are registered.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_inst - program load (IDLE only)
//   prog_len, start    - run request (IDLE only, prog_len 1..DEPTH)
//   INST / ALU_out     - instruction to ALU / ALU result
//   busy               - run in progress
//   res_valid/res_idx/res_data/res_err - per-instruction result strobe
//   error_flag/err_count - divide-by-zero summary of current run
//   done               - end-of-run strobe
module alu_inst_issuer
  import lab_MS_SV4_pack::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  INST_t                    wr_inst,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  output INST_t                    INST,
  input  data_y                    ALU_out,
  output logic                     busy,
  output logic                     res_valid,
  output logic [$clog2(DEPTH)-1:0] res_idx,
  output data_y                    res_data,
  output logic                     res_err,
  output logic                     error_flag,
  output logic [$clog2(DEPTH):0]   err_count,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_RELD  = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  issuer_state_t   state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  INST_t           inst_q, inst_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic [AW-1:0]   res_idx_q, res_idx_d;
  data_y           res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            error_flag_q, error_flag_d;
  logic [AW:0]     err_count_q, err_count_d;
  logic            done_q, done_d;

  logic            mem_we_s;
  INST_t           mem_rdata_s;
  logic            accept_s;
  logic            len_ok_s;

  inst_mem #(.DEPTH(DEPTH)) u_inst_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_addr),
    .wdata (wr_inst),
    .raddr (ptr_q),
    .rdata (mem_rdata_s)
  );

  // IDLE only counts as free once the previous run's done pulse has retired busy.
  assign accept_s = (state_q == IDLE) && !busy_q;
  assign len_ok_s = (prog_len != {(AW+1){1'b0}}) && (prog_len <= LEN_MAX);
  assign mem_we_s = accept_s && wr_en;

  // Next-state and output computation for the issue/wait/capture sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    busy_d       = busy_q;
    res_valid_d  = 1'b0;
    res_idx_d    = res_idx_q;
    res_data_d   = res_data_q;
    res_err_d    = 1'b0;
    error_flag_d = error_flag_q;
    err_count_d  = err_count_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s && start && len_ok_s) begin
          state_d      = ISSUE;
          ptr_d        = {AW{1'b0}};
          len_d        = prog_len;
          error_flag_d = 1'b0;
          err_count_d  = {(AW+1){1'b0}};
          busy_d       = 1'b1;
        end else if (done_q) begin
          busy_d = 1'b0;
        end else begin
          busy_d = busy_q;
        end
      end
      ISSUE: begin
        inst_d  = mem_rdata_s;
        cnt_d   = CNT_RELD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CAPTURE: begin
        res_valid_d = 1'b1;
        res_idx_d   = ptr_q;
        if (is_zero_div(inst_q)) begin
          res_err_d    = 1'b1;
          res_data_d   = {DATA_W{1'b0}};
          error_flag_d = 1'b1;
          err_count_d  = err_count_q + LEN_ONE;
        end else begin
          res_data_d = ALU_out;
        end
        if ({1'b0, ptr_q} == (len_q - LEN_ONE)) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = ISSUE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= {AW{1'b0}};
      len_q        <= {(AW+1){1'b0}};
      cnt_q        <= {CW{1'b0}};
      inst_q       <= '0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= {AW{1'b0}};
      res_data_q   <= {DATA_W{1'b0}};
      res_err_q    <= 1'b0;
      error_flag_q <= 1'b0;
      err_count_q  <= {(AW+1){1'b0}};
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      error_flag_q <= error_flag_d;
      err_count_q  <= err_count_d;
      done_q       <= done_d;
    end
  end

  assign INST       = inst_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_idx    = res_idx_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign error_flag = error_flag_q;
  assign err_count  = err_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_inst_issuer.sv
module tb_alu_inst_issuer;
  import lab_MS_SV4_pack::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  INST_t         wr_inst = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;

  INST_t         inst1, inst3;
  data_y         alu1, alu3;
  logic          busy1, busy3, rv1, rv3, re1, re3, ef1, ef3, dn1, dn3;
  logic [AW-1:0] ri1, ri3;
  data_y         rd1, rd3;
  logic [AW:0]   ec1, ec3;

  int tests = 0;
  int fails = 0;

  // Result capture from the last run.
  int            n1, n3, done_cnt, done_cyc, rv_cnt;
  int            cyc1 [8];
  logic [AW-1:0] idx1 [8];
  data_y         dat1 [8];
  logic          err1 [8];
  int            cyc3 [8];
  data_y         dat3 [8];
  logic          bsy  [64];

  always #5 clk = ~clk;

  alu_inst_issuer #(.DEPTH(DEPTH), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_inst(wr_inst),
    .prog_len(prog_len), .start(start), .INST(inst1), .ALU_out(alu1),
    .busy(busy1), .res_valid(rv1), .res_idx(ri1), .res_data(rd1), .res_err(re1),
    .error_flag(ef1), .err_count(ec1), .done(dn1)
  );

  alu_inst_issuer #(.DEPTH(DEPTH), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_inst(wr_inst),
    .prog_len(prog_len), .start(start), .INST(inst3), .ALU_out(alu3),
    .busy(busy3), .res_valid(rv3), .res_idx(ri3), .res_data(rd3), .res_err(re3),
    .error_flag(ef3), .err_count(ec3), .done(dn3)
  );

  // Reference ALU; divide-by-zero returns junk the issuer must suppress.
  function automatic data_y alu_f(input INST_t i);
    case (i.opc)
      ADD:     return i.op_a + i.op_b;
      SUB:     return i.op_a - i.op_b;
      MUL:     return i.op_a * i.op_b;
      DIV:     return (i.op_b == 0) ? 16'sh7FFF : i.op_a / i.op_b;
      VAR:     return (i.op_b == 0) ? 16'sh1234 : i.op_a % i.op_b;
      default: return 16'sh0000;
    endcase
  endfunction

  // ALU latency models: result valid ALU_LAT edges after INST changes.
  data_y a3_0, a3_1, a3_2;
  always @(posedge clk) begin
    alu1 <= alu_f(inst1);
    a3_0 <= alu_f(inst3);
    a3_1 <= a3_0;
    a3_2 <= a3_1;
  end
  assign alu3 = a3_2;

  function automatic INST_t mk(input opcode_t o, input int a, input int b);
    INST_t t;
    t.opc  = o;
    t.op_a = data_y'(a);
    t.op_b = data_y'(b);
    return t;
  endfunction

  task automatic write_inst(input logic [AW-1:0] a, input INST_t i);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_inst = i;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start a run and record every strobe for ncyc cycles. Optionally writes
  // alongside start, and optionally injects start+write at cycle inj.
  task automatic run(input logic [AW:0] len, input int ncyc, input bit wr_with,
                     input logic [AW-1:0] wa, input INST_t wi, input int inj);
    n1 = 0; n3 = 0; done_cnt = 0; done_cyc = -1; rv_cnt = 0;
    for (int k = 0; k < 64; k++) bsy[k] = 1'b0;
    @(negedge clk);
    start = 1'b1; prog_len = len;
    if (wr_with) begin
      wr_en = 1'b1; wr_addr = wa; wr_inst = wi;
    end
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (cyc == inj) begin
        start = 1'b1; prog_len = 4'd4;
        wr_en = 1'b1; wr_addr = 3'd0; wr_inst = mk(ADD, 100, 100);
      end
      if (cyc < 64) bsy[cyc] = busy1;
      if (rv1) begin
        rv_cnt++;
        if (n1 < 8) begin
          cyc1[n1] = cyc; idx1[n1] = ri1; dat1[n1] = rd1; err1[n1] = re1;
        end
        n1++;
      end
      if (rv3) begin
        if (n3 < 8) begin
          cyc3[n3] = cyc; dat3[n3] = rd3;
        end
        n3++;
      end
      if (dn1) begin
        done_cnt++; done_cyc = cyc;
      end
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy1); end
    tests++; if (done_cnt !== 0 && dn1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", dn1); end
    tests++; if ({rv1, re1, ef1} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {rv1, re1, ef1}); end
    tests++; if ({ri1, rd1, ec1} !== '0) begin fails++; $display("FAIL reset_res got idx %0d data %0d cnt %0d want 0", ri1, rd1, ec1); end
    tests++; if (inst1 !== '0) begin fails++; $display("FAIL reset_inst got %h want 0", inst1); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    data_y exp_d [3];
    exp_d[0] = 16'sd50; exp_d[1] = -16'sd10; exp_d[2] = 16'sd0;
    write_inst(3'd0, mk(ADD, 30, 20));
    write_inst(3'd1, mk(SUB, 10, 20));
    write_inst(3'd2, mk(MUL, 0, 30));
    run(4'd3, 16, 1'b0, 3'd0, '0, -1);
    tests++; if (n1 !== 3) begin fails++; $display("FAIL basic_count got %0d want 3", n1); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (dat1[i] !== exp_d[i]) begin fails++; $display("FAIL basic_data%0d got %0d want %0d", i, dat1[i], exp_d[i]); end
      tests++; if (idx1[i] !== 3'(i)) begin fails++; $display("FAIL basic_idx%0d got %0d want %0d", i, idx1[i], i); end
      tests++; if (err1[i] !== 1'b0) begin fails++; $display("FAIL basic_err%0d got %b want 0", i, err1[i]); end
      tests++; if (cyc1[i] !== 4 + 3 * i) begin fails++; $display("FAIL basic_cyc%0d got %0d want %0d", i, cyc1[i], 4 + 3 * i); end
    end
    tests++; if (done_cnt !== 1 || done_cyc !== 11) begin fails++; $display("FAIL basic_done got cnt %0d cyc %0d want 1 at 11", done_cnt, done_cyc); end
    tests++; if (bsy[1] !== 1'b1 || bsy[11] !== 1'b1 || bsy[12] !== 1'b0) begin fails++; $display("FAIL basic_busy got %b%b%b want 110", bsy[1], bsy[11], bsy[12]); end
    tests++; if (ef1 !== 1'b0 || ec1 !== 4'd0) begin fails++; $display("FAIL basic_errflag got %b/%0d want 0/0", ef1, ec1); end
  endtask

  task automatic test_errors;
    write_inst(3'd0, mk(DIV, 10, 0));
    write_inst(3'd1, mk(VAR, 20, 0));
    write_inst(3'd2, mk(DIV, 10, 2));
    run(4'd3, 16, 1'b0, 3'd0, '0, -1);
    tests++; if (n1 !== 3) begin fails++; $display("FAIL err_count_rv got %0d want 3", n1); end
    tests++; if (err1[0] !== 1'b1 || dat1[0] !== 16'sd0) begin fails++; $display("FAIL err_idx0 got err %b data %0d want 1/0", err1[0], dat1[0]); end
    tests++; if (err1[1] !== 1'b1 || dat1[1] !== 16'sd0) begin fails++; $display("FAIL err_idx1 got err %b data %0d want 1/0", err1[1], dat1[1]); end
    tests++; if (err1[2] !== 1'b0 || dat1[2] !== 16'sd5) begin fails++; $display("FAIL err_idx2 got err %b data %0d want 0/5", err1[2], dat1[2]); end
    tests++; if (ef1 !== 1'b1 || ec1 !== 4'd2) begin fails++; $display("FAIL err_summary got %b/%0d want 1/2", ef1, ec1); end
  endtask

  task automatic test_bad_len;
    logic [AW:0] lens [2];
    lens[0] = 4'd0; lens[1] = 4'd9;
    for (int j = 0; j < 2; j++) begin
      run(lens[j], 10, 1'b0, 3'd0, '0, -1);
      tests++; if (bsy[1] !== 1'b0 || bsy[5] !== 1'b0 || bsy[10] !== 1'b0) begin fails++; $display("FAIL badlen%0d_busy got %b want 0", lens[j], bsy[1] | bsy[5] | bsy[10]); end
      tests++; if (rv_cnt !== 0 || done_cnt !== 0) begin fails++; $display("FAIL badlen%0d_strobes got rv %0d done %0d want 0/0", lens[j], rv_cnt, done_cnt); end
    end
    // An ignored start must not clear the previous run's error summary.
    tests++; if (ef1 !== 1'b1 || ec1 !== 4'd2) begin fails++; $display("FAIL badlen_hold got %b/%0d want 1/2", ef1, ec1); end
  endtask

  task automatic test_mid_reset;
    int seen_done;
    data_y exp_d [4];
    exp_d[0] = 16'sd2; exp_d[1] = 16'sd2; exp_d[2] = 16'sd12; exp_d[3] = 16'sd3;
    write_inst(3'd0, mk(ADD, 1, 1));
    write_inst(3'd1, mk(SUB, 5, 3));
    write_inst(3'd2, mk(MUL, 3, 4));
    write_inst(3'd3, mk(DIV, 9, 3));
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; prog_len = 4'd4;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (dn1) seen_done++;
    end
    // Cycle 5 is the WAIT of instruction index 1.
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({busy1, dn1, rv1, re1, ef1} !== 5'b00000) begin fails++; $display("FAIL midrst_flags got %b want 00000", {busy1, dn1, rv1, re1, ef1}); end
    tests++; if ({ri1, rd1, ec1} !== '0 || inst1 !== '0) begin fails++; $display("FAIL midrst_data got idx %0d data %0d cnt %0d inst %h want 0", ri1, rd1, ec1, inst1); end
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (dn1 || busy1) seen_done++;
    end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL midrst_nodone got %0d want 0", seen_done); end
    run(4'd4, 20, 1'b0, 3'd0, '0, -1);
    tests++; if (n1 !== 4 || done_cnt !== 1) begin fails++; $display("FAIL rerun_count got rv %0d done %0d want 4/1", n1, done_cnt); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (dat1[i] !== exp_d[i] || idx1[i] !== 3'(i)) begin fails++; $display("FAIL rerun_res%0d got idx %0d data %0d want %0d/%0d", i, idx1[i], dat1[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_busy_ignore;
    write_inst(3'd0, mk(ADD, 7, 8));
    write_inst(3'd1, mk(SUB, 9, 4));
    run(4'd2, 14, 1'b0, 3'd0, '0, 3);
    tests++; if (n1 !== 2 || done_cyc !== 8) begin fails++; $display("FAIL busy_len got rv %0d done_cyc %0d want 2/8", n1, done_cyc); end
    tests++; if (dat1[0] !== 16'sd15 || dat1[1] !== 16'sd5) begin fails++; $display("FAIL busy_data got %0d,%0d want 15,5", dat1[0], dat1[1]); end
    run(4'd2, 14, 1'b0, 3'd0, '0, -1);
    tests++; if (n1 !== 2 || dat1[0] !== 16'sd15 || dat1[1] !== 16'sd5) begin fails++; $display("FAIL busy_mem got n %0d data %0d,%0d want 2 15,5", n1, dat1[0], dat1[1]); end
  endtask

  task automatic test_wr_start;
    run(4'd1, 8, 1'b1, 3'd0, mk(ADD, 40, 2), -1);
    tests++; if (n1 !== 1 || dat1[0] !== 16'sd42) begin fails++; $display("FAIL wrstart got n %0d data %0d want 1/42", n1, dat1[0]); end
  endtask

  task automatic test_lat3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_inst(3'd0, mk(ADD, 1, 2));
    run(4'd1, 12, 1'b0, 3'd0, '0, -1);
    tests++; if (n3 !== 1 || cyc3[0] !== 6) begin fails++; $display("FAIL lat3_timing got n %0d cyc %0d want 1 at 6", n3, cyc3[0]); end
    tests++; if (dat3[0] !== 16'sd3) begin fails++; $display("FAIL lat3_data got %0d want 3", dat3[0]); end
  endtask

  initial begin
    done_cnt = 0;
    test_reset();
    test_basic();
    test_errors();
    test_bad_len();
    test_mid_reset();
    test_busy_ignore();
    test_wr_start();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_inst_issuer.md
ALU_INST_ISSUER -- requirements
Module: alu_inst_issuer

Interface
REQ-001 Parameters SHALL be exactly: DEPTH, 8, program memory entries (power of 2); ALU_LAT, 1, cycles from INST change to valid ALU_out (1..4).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be, in order:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  program write strobe, accepted only in IDLE
- wr_addr  in  $clog2(DEPTH)  program write address
- wr_inst  in  INST_t  instruction to store
- prog_len  in  $clog2(DEPTH)+1  number of instructions to run, sampled on start
- start  in  1  run request, accepted only in IDLE
- INST  out  INST_t  instruction driven to ALU
- ALU_out  in  data_y  ALU result
- busy  out  1  high from accepted start until DONE exit
- res_valid  out  1  one-cycle result strobe
- res_idx  out  $clog2(DEPTH)  program index of result
- res_data  out  data_y  captured result
- res_err  out  1  qualifies res_valid: DIV/VAR with op_b == 0
- error_flag  out  1  sticky, any res_err during current run
- err_count  out  $clog2(DEPTH)+1  number of res_err in current run
- done  out  1  one-cycle end-of-run strobe

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-004 IDLE: start=1 and prog_len in 1..DEPTH -> ISSUE, ptr<=0, len<=prog_len, error_flag<=0, err_count<=0; start with prog_len=0 or >DEPTH SHALL be ignored (stay IDLE, no done).
REQ-005 ISSUE: INST<=mem[ptr], wait counter<=ALU_LAT-1, -> WAIT; WAIT: decrement until 0, then -> CAPTURE.
REQ-006 INST SHALL hold stable from ISSUE exit until next ISSUE; ALU_out SHALL be sampled in CAPTURE, exactly ALU_LAT+1 cycles after ISSUE.
REQ-007 CAPTURE: res_valid=1 for one cycle, res_idx=ptr, res_data=ALU_out; if INST.opc is DIV or VAR and INST.op_b==0 then res_err=1, res_data=0, error_flag<=1, err_count++.
REQ-008 CAPTURE: if ptr==len-1 -> DONE, else ptr++ and -> ISSUE; per-instruction throughput SHALL be ALU_LAT+2 cycles.
REQ-009 DONE: done=1 for one cycle, busy=0 next cycle, -> IDLE; error_flag and err_count SHALL hold until next accepted start.
REQ-010 wr_en outside IDLE SHALL be ignored; wr_en and start in same IDLE cycle: write completes, run uses updated memory.
REQ-011 start while busy SHALL be ignored; no queueing.
REQ-012 res_valid, res_err, done SHALL be 0 in every cycle other than stated.
REQ-013 No arithmetic on operands inside this block; res_data width equals data_y, no truncation.

Reset
REQ-014 rst=1 SHALL force IDLE at next edge from any state, including mid-run: busy=0, done=0, res_valid=0, res_err=0, res_idx=0, res_data=0, error_flag=0, err_count=0, INST='0 (opc ADD, operands 0); no done pulse for aborted run.
REQ-015 Program memory contents SHALL NOT be cleared by reset.

Structure
REQ-016 INST_t, data_y, opcode enum (ADD, SUB, MUL, DIV, VAR) SHALL come from shared package lab_MS_SV4_pack; FSM state enum SHALL also be placed there as issuer_state_t.
REQ-017 Program memory SHALL be a sub-module inst_mem (DEPTH x INST_t, sync write, async read); FSM and capture logic in alu_inst_issuer.

Verification (issuer connected to lab_MS_SV4, ALU_LAT=1)
REQ-018 Load {ADD 30,20; SUB 10,20; MUL 0,30}, prog_len=3, start -> res_data 50, -10 (two's complement), 0 at res_idx 0,1,2; res_valid every 3 cycles; done one cycle after last; error_flag=0.
REQ-019 Load {DIV 10,0; VAR 20,0; DIV 10,2} -> res_err=1 with res_data=0 at idx 0,1; idx 2 res_data=5, res_err=0; error_flag=1, err_count=2 after done.
REQ-020 prog_len=0 or DEPTH+1 with start -> busy stays 0, no res_valid, no done for 10 cycles.
REQ-021 rst asserted in WAIT of instruction 2 of a 4-instruction run -> next cycle all outputs at reset values, no done; restart without reload reproduces full correct result set.
REQ-022 start and wr_en pulsed during busy -> ignored; memory read back in next run unchanged; run length unchanged.
REQ-023 ALU_LAT=3 with ADD 1,2 -> res_valid exactly 5 cycles after ISSUE entry, res_data=3.
